cp0_reg: RTL

- Coprocessor-0 register file for the MIPS core.
- Sits directly upstream of the pipeline control block and supplies it with EPC, Status and Cause. It consumes the same committed-exception strobe and type that the control block uses to redirect the PC.
- Holds Count, Compare, Status, Cause, EPC, PrId and Config.
- Services mfc0/mtc0, records exception state, and generates the timer interrupt.

---
 rtl/cp0_reg_pkg.sv | 69 ++++++
 rtl/cp0_reg_if.sv | 36 +++
 rtl/cp0_reg_timer.sv | 45 ++++
 rtl/cp0_reg.sv | 113 +++++++++++
 4 files changed

// File: rtl/cp0_reg_pkg.sv
// Shared CP0 definitions: widths, exception type codes, register numbers,
// ExcCode values, Status/Cause field positions and an exception decoder.
`ifndef RegWidth
`define RegWidth 32
`endif
`ifndef ExceptionTypeWidth
`define ExceptionTypeWidth 5
`endif

package cp0_reg_pkg;

  // Exception type codes carried on excepttype_i
  localparam logic [`ExceptionTypeWidth-1:0] EXCEPTION_INT     = 5'h01;
  localparam logic [`ExceptionTypeWidth-1:0] EXCEPTION_SYSCALL = 5'h08;
  localparam logic [`ExceptionTypeWidth-1:0] EXCEPTION_RI      = 5'h0a;
  localparam logic [`ExceptionTypeWidth-1:0] EXCEPTION_OV      = 5'h0c;
  localparam logic [`ExceptionTypeWidth-1:0] EXCEPTION_TR      = 5'h0d;
  localparam logic [`ExceptionTypeWidth-1:0] EXCEPTION_ERET    = 5'h0e;

  // CP0 register numbers
  localparam logic [4:0] CP0_REG_COUNT   = 5'd9;
  localparam logic [4:0] CP0_REG_COMPARE = 5'd11;
  localparam logic [4:0] CP0_REG_STATUS  = 5'd12;
  localparam logic [4:0] CP0_REG_CAUSE   = 5'd13;
  localparam logic [4:0] CP0_REG_EPC     = 5'd14;
  localparam logic [4:0] CP0_REG_PRID    = 5'd15;
  localparam logic [4:0] CP0_REG_CONFIG  = 5'd16;

  // Cause.ExcCode values
  localparam logic [4:0] EXCCODE_INT = 5'h00;
  localparam logic [4:0] EXCCODE_SYS = 5'h08;
  localparam logic [4:0] EXCCODE_RI  = 5'h0a;
  localparam logic [4:0] EXCCODE_OV  = 5'h0c;
  localparam logic [4:0] EXCCODE_TR  = 5'h0d;

  // Field positions
  localparam int STATUS_EXL   = 1;
  localparam int CAUSE_BD     = 31;
  localparam int CAUSE_EXC_HI = 6;
  localparam int CAUSE_EXC_LO = 2;
  localparam int CAUSE_IP_HI  = 15;
  localparam int CAUSE_IP_LO  = 8;

  // Software-writable Cause bits: IV, WP and IP[1:0]
  localparam logic [`RegWidth-1:0] CAUSE_WR_MASK = 32'h00C0_0300;
  localparam logic [`RegWidth-1:0] STATUS_RST    = 32'h1000_0000;

  typedef struct packed {
    logic       valid;
    logic [4:0] code;
  } exc_dec_t;

  // Map an exception type to its ExcCode; valid=0 for ERET and unknown codes
  function automatic exc_dec_t decode_exc(input logic [`ExceptionTypeWidth-1:0] t);
    exc_dec_t d;
    d.valid = 1'b1;
    d.code  = EXCCODE_INT;
    case (t)
      EXCEPTION_INT:     d.code = EXCCODE_INT;
      EXCEPTION_SYSCALL: d.code = EXCCODE_SYS;
      EXCEPTION_RI:      d.code = EXCCODE_RI;
      EXCEPTION_OV:      d.code = EXCCODE_OV;
      EXCEPTION_TR:      d.code = EXCCODE_TR;
      default:           d.valid = 1'b0;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/cp0_reg_if.sv
// CP0 access/exception bus between the pipeline (master) and cp0_reg (slave).
`ifndef RegWidth
`define RegWidth 32
`endif
`ifndef ExceptionTypeWidth
`define ExceptionTypeWidth 5
`endif

interface cp0_reg_if;
  logic                           we_i;
  logic [4:0]                     waddr_i;
  logic [`RegWidth-1:0]           wdata_i;
  logic [4:0]                     raddr_i;
  logic [`RegWidth-1:0]           rdata_o;
  logic [5:0]                     int_i;
  logic                           exception_en_i;
  logic [`ExceptionTypeWidth-1:0] excepttype_i;
  logic [`RegWidth-1:0]           current_inst_addr_i;
  logic                           is_in_delayslot_i;
  logic [`RegWidth-1:0]           epc_o;
  logic [`RegWidth-1:0]           status_o;
  logic [`RegWidth-1:0]           cause_o;
  logic                           timer_int_o;

  modport master (
    output we_i, waddr_i, wdata_i, raddr_i, int_i, exception_en_i,
           excepttype_i, current_inst_addr_i, is_in_delayslot_i,
    input  rdata_o, epc_o, status_o, cause_o, timer_int_o
  );

  modport slave (
    input  we_i, waddr_i, wdata_i, raddr_i, int_i, exception_en_i,
           excepttype_i, current_inst_addr_i, is_in_delayslot_i,
    output rdata_o, epc_o, status_o, cause_o, timer_int_o
  );
endinterface

// File: rtl/cp0_reg_timer.sv
// cp0_timer: free-running Count, Compare and the registered timer interrupt.
`ifndef RegWidth
`define RegWidth 32
`endif

module cp0_timer (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_we_count,
  input  logic                 i_we_compare,
  input  logic [`RegWidth-1:0] i_wdata,
  output logic [`RegWidth-1:0] o_count,
  output logic [`RegWidth-1:0] o_compare,
  output logic                 o_timer_int
);

  logic [`RegWidth-1:0] r_count;
  logic [`RegWidth-1:0] r_compare;
  logic                 r_timer_int;
  logic                 w_match;

  assign w_match = (r_compare != '0) && (r_count == r_compare);

  // Count ticks every cycle unless loaded; a Compare write acknowledges the interrupt
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count     <= '0;
      r_compare   <= '0;
      r_timer_int <= 1'b0;
    end else begin
      r_count <= i_we_count ? i_wdata : r_count + 1'b1;
      if (i_we_compare) begin
        r_compare   <= i_wdata;
        r_timer_int <= 1'b0;
      end else if (w_match) begin
        r_timer_int <= 1'b1;
      end
    end
  end

  assign o_count     = r_count;
  assign o_compare   = r_compare;
  assign o_timer_int = r_timer_int;

endmodule

// File: rtl/cp0_reg.sv
// cp0_reg: Coprocessor-0 register file (Status, Cause, EPC, PrId, Config and,
// with CP0_TIMER_EN defined, the Count/Compare timer). Without CP0_TIMER_EN,
// Count/Compare read as 0 and timer_int_o is tied low.
`ifndef RegWidth
`define RegWidth 32
`endif

module cp0_reg
  import cp0_reg_pkg::*;
#(
  parameter logic [`RegWidth-1:0] PRID_VAL   = 32'h0000_4220,
  parameter logic [`RegWidth-1:0] CONFIG_RST = 32'h0000_8000
) (
  input  logic     clk,
  input  logic     rst,
  cp0_reg_if.slave bus
);

  logic [`RegWidth-1:0] r_status;
  logic [`RegWidth-1:0] r_cause;
  logic [`RegWidth-1:0] r_epc;
  logic [`RegWidth-1:0] w_count;
  logic [`RegWidth-1:0] w_compare;
  logic [`RegWidth-1:0] w_rdata;
  logic                 w_timer_int;
  logic                 w_wr_en;
  logic                 w_fwd;
  exc_dec_t             w_dec;

  // An exception flushes the instruction carrying a simultaneous mtc0
  assign w_wr_en = bus.we_i & ~bus.exception_en_i;
  assign w_fwd   = bus.we_i && (bus.waddr_i == bus.raddr_i);
  assign w_dec   = decode_exc(bus.excepttype_i);

`ifdef CP0_TIMER_EN
  localparam bit TIMER_EN = 1'b1;

  cp0_timer u_timer (
    .clk          (clk),
    .rst          (rst),
    .i_we_count   (w_wr_en && (bus.waddr_i == CP0_REG_COUNT)),
    .i_we_compare (w_wr_en && (bus.waddr_i == CP0_REG_COMPARE)),
    .i_wdata      (bus.wdata_i),
    .o_count      (w_count),
    .o_compare    (w_compare),
    .o_timer_int  (w_timer_int)
  );
`else
  localparam bit TIMER_EN = 1'b0;

  assign w_count     = '0;
  assign w_compare   = '0;
  assign w_timer_int = 1'b0;
`endif

  // Status/Cause/EPC update: exceptions take priority over mtc0
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_status <= STATUS_RST;
      r_cause  <= '0;
      r_epc    <= '0;
    end else begin
      r_cause[CAUSE_IP_HI:CAUSE_IP_LO+2] <= {bus.int_i[5] | w_timer_int, bus.int_i[4:0]};
      if (bus.exception_en_i) begin
        if (w_dec.valid) begin
          r_status[STATUS_EXL]                <= 1'b1;
          r_cause[CAUSE_EXC_HI:CAUSE_EXC_LO]  <= w_dec.code;
          // EPC/BD only record the outermost exception
          if (!r_status[STATUS_EXL]) begin
            r_cause[CAUSE_BD] <= bus.is_in_delayslot_i;
            r_epc <= bus.is_in_delayslot_i ? bus.current_inst_addr_i - 32'd4
                                           : bus.current_inst_addr_i;
          end
        end else if (bus.excepttype_i == EXCEPTION_ERET) begin
          r_status[STATUS_EXL] <= 1'b0;
        end
      end else if (w_wr_en) begin
        case (bus.waddr_i)
          CP0_REG_STATUS: r_status <= bus.wdata_i;
          CP0_REG_EPC:    r_epc    <= bus.wdata_i;
          CP0_REG_CAUSE: begin
            r_cause[23:22]                   <= bus.wdata_i[23:22];
            r_cause[CAUSE_IP_LO+1:CAUSE_IP_LO] <= bus.wdata_i[CAUSE_IP_LO+1:CAUSE_IP_LO];
          end
          default: ;
        endcase
      end
    end
  end

  // mfc0 read mux, forwarding a same-cycle mtc0 with field masks applied
  always_comb begin
    w_rdata = '0;
    case (bus.raddr_i)
      CP0_REG_COUNT:   w_rdata = (TIMER_EN && w_fwd) ? bus.wdata_i : w_count;
      CP0_REG_COMPARE: w_rdata = (TIMER_EN && w_fwd) ? bus.wdata_i : w_compare;
      CP0_REG_STATUS:  w_rdata = w_fwd ? bus.wdata_i : r_status;
      CP0_REG_CAUSE:   w_rdata = w_fwd ? ((r_cause & ~CAUSE_WR_MASK) | (bus.wdata_i & CAUSE_WR_MASK))
                                       : r_cause;
      CP0_REG_EPC:     w_rdata = w_fwd ? bus.wdata_i : r_epc;
      CP0_REG_PRID:    w_rdata = PRID_VAL;
      CP0_REG_CONFIG:  w_rdata = CONFIG_RST;
      default:         w_rdata = '0;
    endcase
  end

  assign bus.rdata_o     = w_rdata;
  assign bus.epc_o       = r_epc;
  assign bus.status_o    = r_status;
  assign bus.cause_o     = r_cause;
  assign bus.timer_int_o = w_timer_int;

endmodule
